// File: rtl/addsub_result_display.sv
// Captures a 4-bit two's-complement adder result and shows it as signed decimal
// on a 4-digit multiplexed seven-segment display, with "OF" and blinking on overflow.
module addsub_result_display #(
    parameter int REFRESH_CNT = 100000,
    parameter int BLINK_SCANS = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] s,
    input  logic       v,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int RW = $clog2(REFRESH_CNT);
    localparam int BW = $clog2(BLINK_SCANS) + 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CNT - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_SCANS - 1);

    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_F     = 7'b0001110;

    typedef enum logic {ON, OFF} blink_t;

    logic [3:0]    s_reg;
    logic          v_reg;
    logic [RW-1:0] refresh_cnt;
    logic [1:0]    idx;
    logic [BW-1:0] blink_cnt;
    blink_t        blink_state;

    logic          advance;
    logic          neg;
    logic [4:0]    s_ext;
    logic [4:0]    mag;

    assign advance = (refresh_cnt == REFRESH_LAST);

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let the blink logic see the new v_reg.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg <= '0;
            v_reg <= 1'b0;
        end else if (load) begin
            s_reg <= s;
            v_reg <= v;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            idx         <= '0;
        end else if (advance) begin
            refresh_cnt <= '0;
            idx         <= idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // A load that clears overflow resets the blink on the same edge; a load that
    // keeps overflow set lets the timing run on undisturbed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_state <= ON;
            blink_cnt   <= '0;
        end else if ((load && !v) || !v_reg) begin
            blink_state <= ON;
            blink_cnt   <= '0;
        end else if (advance) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_state <= (blink_state == ON) ? OFF : ON;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign neg   = s_reg[3];
    assign s_ext = {s_reg[3], s_reg};
    assign mag   = neg ? (5'd0 - s_ext) : s_ext;

    function automatic logic [6:0] glyph(input logic [4:0] d);
        case (d)
            5'd0:    glyph = 7'b1000000;
            5'd1:    glyph = 7'b1111001;
            5'd2:    glyph = 7'b0100100;
            5'd3:    glyph = 7'b0110000;
            5'd4:    glyph = 7'b0011001;
            5'd5:    glyph = 7'b0010010;
            5'd6:    glyph = 7'b0000010;
            5'd7:    glyph = 7'b1111000;
            5'd8:    glyph = 7'b0000000;
            default: glyph = SEG_BLANK;
        endcase
    endfunction

    // NOTE: seg gets a default before the case so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        seg = SEG_BLANK;
        case (idx)
            2'd0: seg = glyph(mag);
            2'd1: seg = neg ? SEG_MINUS : SEG_BLANK;
            2'd2: seg = v_reg ? SEG_F : SEG_BLANK;
            2'd3: seg = v_reg ? SEG_O : SEG_BLANK;
            default: seg = SEG_BLANK;
        endcase
    end

    assign an = (blink_state == OFF) ? 4'b1111 : ~(4'b0001 << idx);
    assign dp = 1'b1;

endmodule

// File: tb/tb_addsub_result_display.sv
// Scoreboard bench for addsub_result_display: stimulus queues expected display
// state per cycle, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_addsub_result_display;

    localparam logic [6:0] G0    = 7'b1000000;
    localparam logic [6:0] G2    = 7'b0100100;
    localparam logic [6:0] G3    = 7'b0110000;
    localparam logic [6:0] G5    = 7'b0010010;
    localparam logic [6:0] G8    = 7'b0000000;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] GO    = 7'b1000000;
    localparam logic [6:0] GF    = 7'b0001110;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] s;
    logic       v;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    addsub_result_display #(.REFRESH_CNT(4), .BLINK_SCANS(2)) dut (
        .clk(clk), .rst(rst), .load(load), .s(s), .v(v),
        .seg(seg), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   passed = 0;
    int   total  = 0;

    // Bench-side view of what the display should hold
    logic [6:0] dig[4];
    bit         ov;
    int         k;
    int         kl;
    bit         pend;
    logic [6:0] nd[4];
    bit         nv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b", name, act, exp);
        else
            passed++;
    endtask

    // Overflow blink: toggles on every second digit advance after the capture edge
    function automatic bit exp_blink();
        return ov && ((((k / 4) - (kl / 4)) / 2) % 2 == 1);
    endfunction

    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            check({e.name, " an"}, 32'(an), 32'(e.an));
            check({e.name, " seg"}, 32'(seg), 32'(e.seg));
            check({e.name, " dp"}, 32'(dp), 32'd1);
        end
    end

    task automatic tick(input string name);
        exp_t x;
        int   i;
        @(posedge clk);
        #1;
        load = 1'b0;
        k++;
        if (pend) begin
            dig  = nd;
            ov   = nv;
            kl   = k;
            pend = 0;
        end
        i      = (k / 4) % 4;
        x.an   = exp_blink() ? 4'b1111 : ~(4'b0001 << i);
        x.seg  = dig[i];
        x.name = name;
        q.push_back(x);
    endtask

    task automatic load_val(input logic [3:0] sv, input logic vv,
                            input logic [6:0] g0, input logic [6:0] g1,
                            input logic [6:0] g2, input logic [6:0] g3,
                            input string name);
        s     = sv;
        v     = vv;
        load  = 1'b1;
        nd[0] = g0;
        nd[1] = g1;
        nd[2] = g2;
        nd[3] = g3;
        nv    = vv;
        pend  = 1;
        tick(name);
    endtask

    task automatic after_reset();
        k      = 0;
        kl     = 0;
        ov     = 0;
        pend   = 0;
        dig[0] = G0;
        dig[1] = BLANK;
        dig[2] = BLANK;
        dig[3] = BLANK;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t x;
        rst  = 1'b1;
        load = 1'b0;
        s    = 4'd0;
        v    = 1'b0;
        after_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;

        repeat (6) tick("idle");
        load_val(4'b1110, 1'b1, G2, MINUS, GF, GO, "pre_ovf");
        repeat (10) tick("pre_ovf");

        // Reset asserted mid-scan and mid-blink, between edges
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst an", 32'(an), 32'(4'b1110));
        check("async_rst seg", 32'(seg), 32'(G0));
        @(posedge clk);
        #1;
        x.an = 4'b1110; x.seg = G0; x.name = "rst_hold";
        q.push_back(x);
        @(negedge clk);
        #1 rst = 1'b0;
        after_reset();
        repeat (20) tick("post_rst");

        load_val(4'b1101, 1'b0, G3, MINUS, BLANK, BLANK, "neg3");
        repeat (16) tick("neg3");

        load_val(4'b1000, 1'b0, G8, MINUS, BLANK, BLANK, "neg8");
        repeat (16) tick("neg8");

        load_val(4'b1110, 1'b1, G2, MINUS, GF, GO, "ovf");
        repeat (40) tick("ovf");

        while (!exp_blink()) tick("ovf_seek_off");
        load_val(4'b0000, 1'b0, G0, BLANK, BLANK, BLANK, "clear_in_off");
        repeat (64) tick("no_blink");

        while ((k + 1) % 4 != 0) tick("align");
        load_val(4'b0101, 1'b0, G5, BLANK, BLANK, BLANK, "load_on_adv");
        repeat (8) tick("load_on_adv");

        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/addsub_result_display.md
Name: addsub_result_display

Overview:
- Downstream consumer of the 4-bit two's-complement adder/subtractor (s[3:0], overflow v).
- Captures a result on a load strobe and shows it as signed decimal on the board's 4-digit multiplexed seven-segment display.
- On overflow it also shows "OF" and blinks the whole display.
- Contains the digit-scan refresh counter, the blink timer and the result register.

Parameters:
- REFRESH_CNT, 100000, clock cycles each digit stays enabled (>=2).
- BLINK_SCANS, 200, digit advances per blink half-period (>=1).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- load  input  1  single-cycle strobe; captures s and v on this clk edge
- s  input  4  adder result, two's complement, -8..7
- v  input  1  adder overflow flag
- seg  output  7  segments {g,f,e,d,c,b,a}, active low
- an  output  4  digit anodes, active low; an[0] is the rightmost digit
- dp  output  1  decimal point, active low; tied to 1 (off)

Behaviour:
- Reset is asynchronous and active-high (rst). Clears s_reg=0, v_reg=0, refresh count=0, digit index idx=0, blink count=0, blink_off=0. Resulting outputs: an=4'b1110, seg=7'b1000000 (digit "0"), dp=1.
- Capture: when load=1 at a clk edge, s_reg<=s and v_reg<=v. The display reflects the new value from the cycle after that edge. When load=0, the registers hold. There is no handshake; the strobe is fire-and-forget.
- Sign/magnitude:
  - neg = s_reg[3].
  - mag = neg ? (-s_reg) computed in 5 bits : s_reg.
  - mag range is 0..8; s_reg = -8 (4'b1000) gives mag=8, neg=1.
- Refresh counter:
  - Counts 0..REFRESH_CNT-1 every cycle.
  - At terminal count it wraps to 0 and idx advances 0->1->2->3->0.
  - This is a "digit advance" event; idx changes exactly once every REFRESH_CNT cycles.
- Digit content:
  - idx0: glyph(mag).
  - idx1: minus if neg, else blank.
  - idx2: "F" if v_reg, else blank.
  - idx3: "O" if v_reg, else blank.
- Glyphs, as seg values:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000
  - minus=0111111, blank=1111111, O=1000000, F=0001110
- Anodes:
  - an = ~(4'b0001 << idx) when blink_off=0.
  - an = 4'b1111 when blink_off=1.
  - seg keeps being decoded regardless of blink_off.
  - seg and an are combinational from registered state only; s, v and load never feed outputs directly.
- Blink state machine, two states ON and OFF (blink_off):
  - While v_reg=0: forced to ON, blink count held at 0.
  - While v_reg=1: blink count increments on each digit advance. When it reaches BLINK_SCANS-1 with an advance, it wraps to 0 and the state toggles.
  - A load that clears v_reg returns to ON, with count 0, on the same edge that updates v_reg.
  - A load that keeps v_reg=1 does not restart the blink timing.
- Simultaneous events:
  - load coinciding with a digit advance: both take effect on that edge.
  - rst dominates everything, including mid-scan and mid-blink.
- The refresh counter width is clog2(REFRESH_CNT); the blink counter width is clog2(BLINK_SCANS)+1 as needed. Neither counter may overflow past its terminal value.

Test Plan (REFRESH_CNT=4, BLINK_SCANS=2):
- Reset mid-run, then release:
  - Required: an=1110, seg=1000000 immediately on assertion, asynchronously.
  - Required: idx first advances 4 cycles after release.
- Load s=4'b1101 (-3), v=0, then observe 16 cycles:
  - idx0: seg=0110000.
  - idx1: seg=0111111.
  - idx2 and idx3: seg=1111111.
  - an walks 1110->1101->1011->0111, 4 cycles each.
- Load s=4'b1000 (-8), v=0:
  - Required: idx0 seg=0000000 (8), idx1 minus.
- Load s=4'b0111, v=1 (7+7 overflow wraps to s=1110; drive that):
  - Required: "-2" on idx1/idx0, F on idx2, O on idx3.
  - Required: an=1111 for 8 cycles after every 8 lit cycles.
- During a blink OFF phase, load s=4'b0000, v=0:
  - Required: next cycle an is lit, and blink never recurs over 64 cycles.
- Load asserted on a digit-advance edge:
  - Required: the new value is shown on the new idx in the following cycle, with no skipped digit.
